// File: rtl/uart_link_ctrl.sv
// Link sequencer between the UART byte interface and the miner core: frames received
// bytes into a block header and serialises found nonces as framed 5-byte reports.
module uart_link_ctrl #(
    parameter logic [7:0] SYNC_RX        = 8'hA5,
    parameter logic [7:0] SYNC_TX        = 8'h5A,
    parameter int         HEADER_BYTES   = 80,
    parameter int         TIMEOUT_CYCLES = 5000000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx_rdy,
    input  logic [7:0]                  rx_data,
    output logic                        rdy_clr,
    input  logic                        tx_busy,
    output logic [7:0]                  tx_din,
    output logic                        tx_wr_en,
    input  logic                        nonce_found,
    input  logic [31:0]                 nonce_in,
    output logic [8*HEADER_BYTES-1:0]   header_data,
    output logic                        header_valid,
    output logic [15:0]                 rx_err_count,
    output logic [15:0]                 tx_drop_count
);

    localparam int HDR_W = 8 * HEADER_BYTES;
    localparam int IDX_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rx_state_t;
    typedef enum logic [1:0] {T_IDLE = 2'd0, T_LOAD = 2'd1, T_STROBE = 2'd2, T_WAIT = 2'd3} tx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] msg_byte(input logic [39:0] msg, input logic [2:0] idx);
        case (idx)
            3'd0:    msg_byte = msg[39:32];
            3'd1:    msg_byte = msg[31:24];
            3'd2:    msg_byte = msg[23:16];
            3'd3:    msg_byte = msg[15:8];
            3'd4:    msg_byte = msg[7:0];
            default: msg_byte = 8'h00;
        endcase
    endfunction

    rx_state_t          rx_state_r;
    logic               armed_off_r;
    logic               rdy_clr_r;
    logic               take_s;
    logic [IDX_W-1:0]   idx_r;
    logic [TO_W-1:0]    gap_r;
    logic [HDR_W-1:0]   shadow_r;
    logic               commit_r;
    logic [HDR_W-1:0]   header_data_r;
    logic               header_valid_r;
    logic [15:0]        rx_err_r;

    tx_state_t          tx_state_r;
    logic               pend_full_r;
    logic [31:0]        pend_r;
    logic               pop_s;
    logic [39:0]        msg_r;
    logic [2:0]         cnt_r;
    logic               guard_r;
    logic [7:0]         tx_din_r;
    logic               tx_wr_en_r;
    logic [15:0]        drop_r;

    // A byte is consumed once per rx_rdy assertion; re-arm only after rx_rdy drops.
    assign take_s = rx_rdy & ~armed_off_r;
    assign pop_s  = (tx_state_r == T_IDLE) & pend_full_r;

    // Receive handshake: one-cycle clear pulse and re-arm tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            armed_off_r <= 1'b0;
            rdy_clr_r   <= 1'b0;
        end else begin
            rdy_clr_r <= take_s;
            if (take_s) begin
                armed_off_r <= 1'b1;
            end else if (!rx_rdy) begin
                armed_off_r <= 1'b0;
            end
        end
    end

    // Receive framer: sync hunt, payload capture, inter-byte timeout, header commit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_r     <= R_IDLE;
            idx_r          <= '0;
            gap_r          <= '0;
            shadow_r       <= '0;
            commit_r       <= 1'b0;
            header_data_r  <= '0;
            header_valid_r <= 1'b0;
            rx_err_r       <= 16'h0000;
        end else begin
            commit_r       <= 1'b0;
            header_valid_r <= commit_r;
            if (commit_r) begin
                header_data_r <= shadow_r;
            end
            case (rx_state_r)
                R_IDLE: begin
                    gap_r <= '0;
                    if (take_s && (rx_data == SYNC_RX)) begin
                        idx_r      <= '0;
                        rx_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (take_s) begin
                        gap_r <= '0;
                        for (int i = 0; i < HEADER_BYTES; i++) begin
                            if (idx_r == IDX_W'(i)) begin
                                shadow_r[HDR_W-1-8*i -: 8] <= rx_data;
                            end
                        end
                        if (idx_r == IDX_W'(HEADER_BYTES - 1)) begin
                            commit_r   <= 1'b1;
                            rx_state_r <= R_IDLE;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else if (gap_r == TO_W'(TIMEOUT_CYCLES)) begin
                        rx_err_r   <= sat_inc(rx_err_r);
                        rx_state_r <= R_IDLE;
                    end else begin
                        gap_r <= gap_r + TO_W'(1);
                    end
                end
                default: rx_state_r <= R_IDLE;
            endcase
        end
    end

    // Single-entry nonce slot; a write is allowed in the same cycle the sender empties it
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_full_r <= 1'b0;
            pend_r      <= 32'h0000_0000;
            drop_r      <= 16'h0000;
        end else if (nonce_found && (!pend_full_r || pop_s)) begin
            pend_r      <= nonce_in;
            pend_full_r <= 1'b1;
        end else begin
            if (nonce_found) begin
                drop_r <= sat_inc(drop_r);
            end
            if (pop_s) begin
                pend_full_r <= 1'b0;
            end
        end
    end

    // Transmit sequencer: byte load, write strobe, busy-guarded wait
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_r <= T_IDLE;
            msg_r      <= 40'h00_0000_0000;
            cnt_r      <= 3'd0;
            guard_r    <= 1'b0;
            tx_din_r   <= 8'h00;
            tx_wr_en_r <= 1'b0;
        end else begin
            case (tx_state_r)
                T_IDLE: begin
                    tx_wr_en_r <= 1'b0;
                    if (pop_s) begin
                        msg_r      <= {SYNC_TX, pend_r};
                        cnt_r      <= 3'd0;
                        tx_state_r <= T_LOAD;
                    end
                end
                T_LOAD: begin
                    tx_din_r   <= msg_byte(msg_r, cnt_r);
                    tx_wr_en_r <= 1'b1;
                    tx_state_r <= T_STROBE;
                end
                T_STROBE: begin
                    tx_wr_en_r <= 1'b0;
                    guard_r    <= 1'b1;
                    tx_state_r <= T_WAIT;
                end
                T_WAIT: begin
                    tx_wr_en_r <= 1'b0;
                    // The UART may not have raised busy yet on the first wait cycle.
                    if (guard_r) begin
                        guard_r <= 1'b0;
                    end else if (!tx_busy) begin
                        if (cnt_r < 3'd4) begin
                            cnt_r      <= cnt_r + 3'd1;
                            tx_state_r <= T_LOAD;
                        end else begin
                            tx_state_r <= T_IDLE;
                        end
                    end
                end
                default: begin
                    tx_wr_en_r <= 1'b0;
                    tx_state_r <= T_IDLE;
                end
            endcase
        end
    end

    assign rdy_clr       = rdy_clr_r;
    assign header_data   = header_data_r;
    assign header_valid  = header_valid_r;
    assign rx_err_count  = rx_err_r;
    assign tx_din        = tx_din_r;
    assign tx_wr_en      = tx_wr_en_r;
    assign tx_drop_count = drop_r;

endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
Sequences the UART byte datapath for the miner. On receive, it frames incoming bytes into an 80-byte block header and presents it to the hash core. On transmit, it serialises found nonces as framed 5-byte messages, one byte at a time, through the shared UART transmitter. It sits between the uart instance and the miner core, and replaces any fixed header constant.

Parameters:
SYNC_RX, 8'hA5, start-of-header marker byte
SYNC_TX, 8'h5A, start-of-nonce-report marker byte
HEADER_BYTES, 80, payload bytes per header frame
TIMEOUT_CYCLES, 5000000, max clock cycles between bytes inside a frame (0.1 s at 50 MHz)

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
rx_rdy  in  1  uart receive-ready flag (level; held until cleared)
rx_data  in  8  uart received byte
rdy_clr  out  1  clear pulse to uart receive-ready
tx_busy  in  1  uart transmitter busy
tx_din  out  8  byte to uart transmitter
tx_wr_en  out  1  one-cycle write strobe to uart transmitter
nonce_found  in  1  one-cycle pulse from the miner
nonce_in  in  32  nonce, sampled when nonce_found is high
header_data  out  640  last complete header; the first byte received lands in [639:632]
header_valid  out  1  one-cycle pulse when header_data is updated
rx_err_count  out  16  count of aborted/timed-out frames, saturating
tx_drop_count  out  16  count of dropped nonces, saturating

Behaviour:
- Reset values: all outputs 0; header_data 0; both FSMs return to IDLE; the pending slot is empty. Reset mid-frame discards the partial header and does not change the error count (which is also cleared).
- RX byte strobe: when rx_rdy=1 and the block is not armed-off, capture rx_data and drive rdy_clr=1 for exactly 1 cycle. The block is then armed-off until rx_rdy is seen 0. Each byte is consumed exactly once.
- RX FSM states: R_IDLE, R_DATA.
  - R_IDLE: a byte equal to SYNC_RX -> R_DATA, idx=0. Any other byte is ignored silently.
  - R_DATA: each byte is written to shadow[639-8*idx -: 8] and idx increments.
  - When idx reaches HEADER_BYTES-1 and that byte is written: copy shadow to header_data on the next edge, pulse header_valid for 1 cycle in that same cycle, then -> R_IDLE.
  - A SYNC_RX byte inside R_DATA is ordinary data; there is no escaping.
- Timeout: the gap counter resets on every byte in R_DATA. When the counter reaches TIMEOUT_CYCLES, go to R_IDLE, increment rx_err_count, and leave header_data unchanged.
- header_data changes only on a complete frame. It holds its value through partial and aborted frames.
- TX message: SYNC_TX, then nonce[31:24], [23:16], [15:8], [7:0], in that order (5 bytes).
- TX FSM states: T_IDLE, T_LOAD, T_STROBE, T_WAIT.
  - T_IDLE: if the pending slot is full, move it to the working register, set cnt=0 -> T_LOAD.
  - T_LOAD: drive tx_din = byte[cnt] -> T_STROBE.
  - T_STROBE: tx_wr_en=1 for 1 cycle; tx_din is held stable through T_WAIT -> T_WAIT.
  - T_WAIT: ignore tx_busy for the first cycle (guard). Then wait for tx_busy=0. If cnt<4: cnt++ -> T_LOAD. Otherwise -> T_IDLE.
  - Minimum spacing between strobes is 3 cycles. tx_wr_en is never asserted while tx_busy=1, except in the guard cycle.
- Pending slot: 1 entry. nonce_found writes it when it is empty, or in the same cycle T_IDLE empties it.
  - nonce_found while the slot is full and not being emptied: the new nonce is dropped and tx_drop_count increments.
  - The in-flight message is never corrupted.
- RX and TX run fully concurrently and are independent.
- Counters saturate at 16'hFFFF.

Test Plan:
- Send A5 followed by bytes 00..4F at UART bit timing -> exactly one header_valid pulse. header_data[639:632]=8'h00, [7:0]=8'h4F. rdy_clr pulses 81 times. rx_err_count=0.
- Send 3C, 11, then A5 + 80 bytes -> the 3C and 11 bytes are ignored, one header is accepted, and header_data matches the 80 bytes.
- Send A5 + 40 bytes, stall longer than TIMEOUT_CYCLES (use a reduced value, e.g. 1000), then a full valid frame -> rx_err_count=1. header_data shows the old value until the second frame, then the new value. One header_valid pulse total.
- Pulse nonce_found with nonce_in=32'h42A14695 -> tx_wr_en pulses 5 times with tx_din = 5A, 42, A1, 46, 95. Each pulse occurs only after tx_busy has fallen.
- Pulse three nonces (N1, N2, N3) back-to-back during N1 transmission -> N1 is sent, N2 is sent, N3 is dropped, tx_drop_count=1.
- Assert reset in the middle of an RX frame and during the TX byte 2 wait -> all outputs are 0 the cycle after reset. No further tx_wr_en pulses occur. The next full frame is accepted normally.
